// File: rtl/fd_pkg.sv
// fd_pkg: shared types and default widths for the fd_multicycle execution core.
//   op_e    - instruction opcode encoding seen on the op field
//   state_e - sequencing FSM states
//   *_DEF   - default parameter values
package fd_pkg;

    localparam int unsigned XLEN_DEF      = 64;
    localparam int unsigned NREG_DEF      = 32;
    localparam int unsigned MEM_DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StMem,
        StWb
    } state_e;

endpackage

// File: rtl/fd_multicycle_if.sv
// fd_multicycle_if: instruction/preload request and completion bundle for fd_multicycle.
//   master - issuer (control unit / host): drives start, op, ra, rb, rw, offset, host_*
//   slave  - execution core: drives busy, done, result, mem_err
interface fd_multicycle_if
    import fd_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned NREG      = NREG_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned RW_W      = $clog2(NREG),
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) ();

    logic            start;
    logic [1:0]      op;
    logic [RW_W-1:0] ra;
    logic [RW_W-1:0] rb;
    logic [RW_W-1:0] rw;
    logic [XLEN-1:0] offset;
    logic            host_we;
    logic [AW-1:0]   host_addr;
    logic [XLEN-1:0] host_wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            mem_err;

    modport master (
        output start, op, ra, rb, rw, offset, host_we, host_addr, host_wdata,
        input  busy, done, result, mem_err
    );

    modport slave (
        input  start, op, ra, rb, rw, offset, host_we, host_addr, host_wdata,
        output busy, done, result, mem_err
    );

endinterface

// File: rtl/fd_regfile.sv
// fd_regfile: NREG x XLEN register file, register 0 hardwired to zero.
//   clk_i, rst_i          - clock, synchronous active-high clear of all registers
//   raddr_a_i/rdata_a_o   - combinational read port A
//   raddr_b_i/rdata_b_o   - combinational read port B
//   we_i/waddr_i/wdata_i  - synchronous write port (writes to register 0 are dropped)
module fd_regfile #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    localparam int unsigned RW_W = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RW_W-1:0] raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [RW_W-1:0] raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [RW_W-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/fd_multicycle.sv
// fd_multicycle: multicycle LD/ST/ADD/SUB execution core with register file, data memory
// and add/sub ALU sequenced by IDLE -> READ -> EXEC -> (MEM) -> (WB) -> IDLE.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (aborts any pending write)
//   bus  - fd_multicycle_if.slave: start/op/ra/rb/rw/offset request, host_* memory preload,
//          busy/done/result/mem_err status
// Optional feature: define FD_MEM_BOUNDS_CHECK_EN to flag full-width addresses >= MEM_DEPTH
// (ST suppressed, LD returns 0); otherwise addresses wrap and mem_err is tied low.
module fd_multicycle
    import fd_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned NREG      = NREG_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    fd_multicycle_if.slave bus
);

    localparam int unsigned RW_W = $clog2(NREG);
    localparam int unsigned AW   = $clog2(MEM_DEPTH);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [RW_W-1:0] ra_q, rb_q, rw_q;
    logic [XLEN-1:0] offset_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] result_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] rdata_a, rdata_b;
    logic [XLEN-1:0] alu_b, alu_sum;
    logic            is_mem_op;
    logic            oob;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem [MEM_DEPTH];

    assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = is_mem_op ? StMem : StWb;
            StMem:   state_d = (op_q == OP_LD) ? StWb : StIdle;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StWb) || ((state_q == StMem) && (op_q == OP_ST));
    assign bus.result = result_q;

    // LD/ST add the offset; ADD/SUB use the second register operand.
    always_comb begin
        alu_b   = is_mem_op ? offset_q : b_q;
        alu_sum = (op_q == OP_SUB) ? (a_q - alu_b) : (a_q + alu_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OP_LD;
            ra_q     <= '0;
            rb_q     <= '0;
            rw_q     <= '0;
            offset_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addr_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            // Fields are captured at acceptance so the issuer may move on after the start cycle.
            if ((state_q == StIdle) && bus.start) begin
                op_q     <= op_e'(bus.op);
                ra_q     <= bus.ra;
                rb_q     <= bus.rb;
                rw_q     <= bus.rw;
                offset_q <= bus.offset;
            end
            if (state_q == StRead) begin
                a_q <= rdata_a;
                b_q <= rdata_b;
            end
            // result_q is loaded on the edge entering the done cycle, and doubles as the
            // write-back data for ADD/SUB/LD.
            if (state_q == StExec) begin
                addr_q <= alu_sum[AW-1:0];
                if (!is_mem_op) begin
                    result_q <= alu_sum;
                end else if (op_q == OP_ST) begin
                    result_q <= b_q;
                end
            end
            if ((state_q == StMem) && (op_q == OP_LD)) begin
                result_q <= oob ? '0 : mem[addr_q];
            end
        end
    end

`ifdef FD_MEM_BOUNDS_CHECK_EN
    logic oob_q, mem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q     <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_q == StExec) begin
                oob_q <= (alu_sum >= XLEN'(MEM_DEPTH));
                // LD reports at the MEM->WB edge instead, alongside its result.
                if (op_q != OP_LD) begin
                    mem_err_q <= (op_q == OP_ST) && (alu_sum >= XLEN'(MEM_DEPTH));
                end
            end
            if ((state_q == StMem) && (op_q == OP_LD)) begin
                mem_err_q <= oob_q;
            end
        end
    end

    assign oob         = oob_q;
    assign bus.mem_err = mem_err_q;
`else
    assign oob         = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    // Single memory write port: host preload in IDLE, ST in MEM; both states are exclusive.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.host_addr;
        mem_wdata = bus.host_wdata;
        if ((state_q == StIdle) && bus.host_we) begin
            mem_we = 1'b1;
        end else if ((state_q == StMem) && (op_q == OP_ST) && !oob) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = b_q;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    fd_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (ra_q),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rb_q),
        .rdata_b_o (rdata_b),
        .we_i      ((state_q == StWb) && !rst),
        .waddr_i   (rw_q),
        .wdata_i   (result_q)
    );

endmodule

// File: tb/tb_fd_multicycle.sv
// Self-checking bench for fd_multicycle: directed scenarios plus randomized instructions,
// all compared against an architectural model (register array + memory array).
module tb_fd_multicycle;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NREG      = 32;
    localparam int unsigned MEM_DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fd_multicycle_if #(.XLEN(XLEN), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)) bus ();

    fd_multicycle #(.XLEN(XLEN), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [63:0] m_reg [32];
    logic [63:0] m_mem [32];

    // Architectural reference: computes expected result/err/latency and updates state.
    task automatic model_step(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] rw, input logic [63:0] off,
                              output logic [63:0] res, output logic err, output int lat);
        logic [63:0] a, b, addr;
        int          idx;
        a    = (ra == 0) ? 64'd0 : m_reg[ra];
        b    = (rb == 0) ? 64'd0 : m_reg[rb];
        addr = a + off;
        idx  = int'(addr % 64'd32);
        err  = 1'b0;
`ifdef FD_MEM_BOUNDS_CHECK_EN
        if (op[1] == 1'b0 && addr >= 64'd32) err = 1'b1;
`endif
        case (op)
            2'b00: begin lat = 4; res = err ? 64'd0 : m_mem[idx]; end
            2'b01: begin lat = 3; res = b; if (!err) m_mem[idx] = b; end
            2'b10: begin lat = 3; res = a + b; end
            default: begin lat = 3; res = a - b; end
        endcase
        if (op != 2'b01 && rw != 0) m_reg[rw] = res;
    endtask

    task automatic host_write(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        bus.host_we    = 1'b1;
        bus.host_addr  = addr;
        bus.host_wdata = data;
        @(negedge clk);
        bus.host_we    = 1'b0;
        m_mem[addr]    = data;
    endtask

    // Issues one instruction, scrambles the request fields after acceptance, waits for done.
    task automatic run_instr(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] rw, input logic [63:0] off,
                             output logic [63:0] res, output logic err, output int lat,
                             output logic busy1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.ra     = ra;
        bus.rb     = rb;
        bus.rw     = rw;
        bus.offset = off;
        @(posedge clk);
        @(negedge clk);
        busy1      = bus.busy;
        bus.start  = 1'b0;
        bus.op     = 2'($urandom);
        bus.ra     = 5'($urandom);
        bus.rb     = 5'($urandom);
        bus.rw     = 5'($urandom);
        bus.offset = {$urandom, $urandom};
        lat = 1;
        while (!bus.done && lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        err = bus.mem_err;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.ra = 0; bus.rb = 0; bus.rw = 0; bus.offset = 0;
        bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
        else pass_cnt++;
        chk_cnt++; if (bus.result !== 64'd0) $display("FAIL reset_result got %h want 0", bus.result);
        else pass_cnt++;
        chk_cnt++; if (bus.mem_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.mem_err);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
    endtask

    // Runs a table of instructions, checking each against the model.
    task automatic run_table(input string name, input logic [1:0] ops[], input logic [4:0] ras[],
                             input logic [4:0] rbs[], input logic [4:0] rws[],
                             input logic [63:0] offs[]);
        logic [63:0] res, eres;
        logic        err, eerr, busy1;
        int          lat, elat;
        for (int i = 0; i < ops.size(); i++) begin
            model_step(ops[i], ras[i], rbs[i], rws[i], offs[i], eres, eerr, elat);
            run_instr(ops[i], ras[i], rbs[i], rws[i], offs[i], res, err, lat, busy1);
            chk_cnt++;
            if (res !== eres) $display("FAIL %s[%0d] result got %h want %h", name, i, res, eres);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== elat) $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, elat);
            else pass_cnt++;
            chk_cnt++;
            if (err !== eerr) $display("FAIL %s[%0d] mem_err got %b want %b", name, i, err, eerr);
            else pass_cnt++;
            chk_cnt++;
            if (busy1 !== 1'b1) $display("FAIL %s[%0d] busy_after_start got %b want 1", name, i, busy1);
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 32; i++) host_write(5'(i), {$urandom, $urandom});
        host_write(5'd1, 64'd10);
        host_write(5'd2, 64'd20);
        run_table("load", '{2'b00, 2'b00}, '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd1, 5'd2},
                  '{64'd1, 64'd2});
        chk_cnt++; if (m_reg[2] !== 64'd20) $display("FAIL load_model got %0d want 20", m_reg[2]);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        run_table("alu", '{2'b10, 2'b11, 2'b11}, '{5'd2, 5'd3, 5'd0}, '{5'd1, 5'd1, 5'd1},
                  '{5'd3, 5'd4, 5'd5}, '{64'd0, 64'd0, 64'd0});
    endtask

    task automatic test_store_load();
        run_table("stld", '{2'b01, 2'b01, 2'b00, 2'b00}, '{5'd0, 5'd0, 5'd0, 5'd0},
                  '{5'd3, 5'd4, 5'd0, 5'd0}, '{5'd0, 5'd0, 5'd6, 5'd7},
                  '{64'd3, 64'd4, 64'd3, 64'd4});
    endtask

    // start and host_we pulsed while busy must be ignored; host_we with start in IDLE is taken.
    task automatic test_busy_ignore();
        int          dones;
        logic [63:0] eres, res;
        logic        eerr;
        int          elat;
        logic [63:0] junk;
        junk = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1; bus.op = 2'b10; bus.ra = 5'd1; bus.rb = 5'd2; bus.rw = 5'd11;
        bus.host_we = 1; bus.host_addr = 5'd6; bus.host_wdata = 64'h1234_5678_9abc_def0;
        m_mem[6] = 64'h1234_5678_9abc_def0;
        model_step(2'b10, 5'd1, 5'd2, 5'd11, 64'd0, eres, eerr, elat);
        dones = 0;
        res = 64'd0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= 2) begin
                bus.start = 1; bus.op = 2'b01; bus.ra = 5'd0; bus.rb = 5'd1; bus.offset = 64'd5;
                bus.host_we = 1; bus.host_addr = 5'd5; bus.host_wdata = junk;
            end else begin
                bus.start = 0; bus.host_we = 0;
            end
            if (bus.done) begin dones++; res = bus.result; end
        end
        bus.start = 0; bus.host_we = 0;
        chk_cnt++; if (dones !== 1) $display("FAIL busy_ignore done_count got %0d want 1", dones);
        else pass_cnt++;
        chk_cnt++; if (res !== eres) $display("FAIL busy_ignore result got %h want %h", res, eres);
        else pass_cnt++;
        run_table("busyld", '{2'b00, 2'b00}, '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd12, 5'd13},
                  '{64'd5, 64'd6});
    endtask

    task automatic test_x0();
        run_table("x0", '{2'b10, 2'b10}, '{5'd1, 5'd0}, '{5'd2, 5'd1}, '{5'd0, 5'd8},
                  '{64'd0, 64'd0});
    endtask

    // Address 40 is out of range for a 32-word memory; behaviour depends on the build.
    task automatic test_oob();
        run_table("oob", '{2'b00, 2'b01, 2'b00}, '{5'd0, 5'd0, 5'd0}, '{5'd0, 5'd1, 5'd0},
                  '{5'd13, 5'd0, 5'd14}, '{64'd40, 64'd40, 64'd8});
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.start = 1; bus.op = 2'b10; bus.ra = 5'd1; bus.rb = 5'd2; bus.rw = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", bus.busy);
        else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_mid done got %b want 0", bus.done);
        else pass_cnt++;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk_cnt++; if (dones !== 0) $display("FAIL rst_mid activity got %0d want 0", dones);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        run_table("rstmid", '{2'b10, 2'b00}, '{5'd9, 5'd0}, '{5'd0, 5'd0}, '{5'd10, 5'd15},
                  '{64'd0, 64'd1});
        chk_cnt++; if (m_reg[15] !== 64'd10) $display("FAIL rst_mid mem1 got %0d want 10", m_reg[15]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [1:0]  ops[];
        logic [4:0]  ras[], rbs[], rws[];
        logic [63:0] offs[];
        ops = new[30]; ras = new[30]; rbs = new[30]; rws = new[30]; offs = new[30];
        for (int i = 0; i < 30; i++) begin
            ops[i]  = 2'($urandom);
            ras[i]  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 15)) : 5'd0;
            rbs[i]  = 5'($urandom_range(0, 15));
            rws[i]  = 5'($urandom_range(0, 15));
            offs[i] = 64'($urandom_range(0, 45));
        end
        run_table("rand", ops, ras, rbs, rws, offs);
    endtask

    // Reads every register back through ADD x0 = xi + x0.
    task automatic test_regdump();
        logic [1:0]  ops[];
        logic [4:0]  ras[], rbs[], rws[];
        logic [63:0] offs[];
        ops = new[32]; ras = new[32]; rbs = new[32]; rws = new[32]; offs = new[32];
        for (int i = 0; i < 32; i++) begin
            ops[i] = 2'b10; ras[i] = 5'(i); rbs[i] = 5'd0; rws[i] = 5'd0; offs[i] = 64'd0;
        end
        run_table("regdump", ops, ras, rbs, rws, offs);
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_store_load();
        test_busy_ignore();
        test_x0();
        test_oob();
        test_reset_mid();
        test_random();
        test_regdump();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
